// File: rtl/wishbone_sram_slave.sv
// -----------------------------------------------------------------------------
// wishbone_sram_slave
//
// Wishbone classic-cycle slave backed by an internal 32-bit word SRAM with
// byte-lane writes. Each access is accepted in IDLE, optionally held for
// WAIT_CYCLES cycles in WAIT (aborted if the master drops cyc/stb), and then
// terminated by a single RESP cycle carrying ack (in range) or err (out of
// range). All bus outputs come straight from flops.
//
// Parameters
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  extra cycles between acceptance and response (0..15)
//
// Ports
//   clk_i     in   1   clock
//   rst_i     in   1   reset, asynchronous, active-high
//   wb_cyc_i  in   1   bus cycle in progress
//   wb_stb_i  in   1   strobe, request valid
//   wb_we_i   in   1   1 = write, 0 = read
//   wb_sel_i  in   4   byte-lane select (bit n -> dat[8n+7:8n])
//   wb_adr_i  in   32  byte address (bits [1:0] ignored)
//   wb_dat_i  in   32  write data
//   wb_dat_o  out  32  read data, non-zero only in a read ack cycle
//   wb_ack_o  out  1   normal termination, one-cycle pulse
//   wb_err_o  out  1   error termination (out of range), one-cycle pulse
//   wb_rty_o  out  1   retry, always 0
// -----------------------------------------------------------------------------
module wishbone_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L   = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [29:0] adr_q;      // word address of the accepted request
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic        ack_q;
    logic        err_q;
    logic        rty_q;
    logic [31:0] rdat_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        req_s;
    logic [29:0] eff_adr_s;
    logic        eff_we_s;
    logic [3:0]  eff_sel_s;
    logic [31:0] eff_dat_s;
    logic        borrow_s;
    logic [29:0] word_off_s;
    logic        in_range_s;
    logic [IDX_W-1:0] idx_s;
    logic        enter_resp_s;
    logic        mem_we_s;
    logic        unused_adr_lsb_s;

    assign req_s = wb_cyc_i & wb_stb_i;

    // Byte-offset bits never reach the decode; the word address is all that matters.
    assign unused_adr_lsb_s = ^wb_adr_i[1:0];

    // With no wait states the response is produced on the accepting edge itself,
    // so the decode must look at the live bus instead of the request registers.
    always_comb begin
        eff_adr_s = adr_q;
        eff_we_s  = we_q;
        eff_sel_s = sel_q;
        eff_dat_s = dat_q;
        if (state_q == ST_IDLE) begin
            eff_adr_s = wb_adr_i[31:2];
            eff_we_s  = wb_we_i;
            eff_sel_s = wb_sel_i;
            eff_dat_s = wb_dat_i;
        end else begin
            eff_adr_s = adr_q;
            eff_we_s  = we_q;
            eff_sel_s = sel_q;
            eff_dat_s = dat_q;
        end
    end

    // Word-granular subtraction; the borrow flags addresses below BASE_ADDR.
    assign {borrow_s, word_off_s} = {1'b0, eff_adr_s} - {1'b0, BASE_ADDR[31:2]};
    assign in_range_s = ~borrow_s & ({2'b00, word_off_s} < DEPTH_L);
    assign idx_s      = word_off_s[IDX_W-1:0];

    // Flags the edge on which the FSM moves into RESP.
    always_comb begin
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: enter_resp_s = req_s & NO_WAIT;
            ST_WAIT: enter_resp_s = req_s & (cnt_q == 4'd1);
            default: enter_resp_s = 1'b0;
        endcase
    end

    // rst_i gates the write so a clock edge during reset can never commit.
    assign mem_we_s = enter_resp_s & eff_we_s & in_range_s & ~rst_i;

    // SRAM array write port with per-byte enables; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_sel_s[b]) begin
                    mem[idx_s][8*b +: 8] <= eff_dat_s[8*b +: 8];
                end
            end
        end
    end

    // Access FSM with request capture and registered bus outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 30'd0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            rdat_q  <= 32'd0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rty_q  <= 1'b0;
            rdat_q <= 32'd0;
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        adr_q <= wb_adr_i[31:2];
                        we_q  <= wb_we_i;
                        sel_q <= wb_sel_i;
                        dat_q <= wb_dat_i;
                        if (NO_WAIT) begin
                            state_q <= ST_RESP;
                            cnt_q   <= 4'd0;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!req_s) begin
                        // Master abandoned the access: nothing commits, no termination.
                        state_q <= ST_IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= ST_RESP;
                        cnt_q   <= 4'd0;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase

            if (enter_resp_s) begin
                ack_q <= in_range_s;
                err_q <= ~in_range_s;
                if (in_range_s && !eff_we_s) begin
                    rdat_q <= mem[idx_s];
                end else begin
                    rdat_q <= 32'd0;
                end
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = rty_q;
    assign wb_dat_o = rdat_q;

endmodule

// File: tb/tb_wishbone_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_wishbone_sram_slave
//
// Two slave instances share one clock:
//   [0] BASE = 0x1000, 16 words, no wait states
//   [1] BASE = 0x0000, 32 words, 3 wait states
// Each request pushes its expected termination (ack/err, data, latency) onto a
// scoreboard queue, computed from a byte-lane reference model; the entry is
// popped and compared when the slave terminates the access.
// -----------------------------------------------------------------------------
module tb_wishbone_sram_slave;

    localparam logic [31:0] B0 = 32'h0000_1000;
    localparam int          D0 = 16;
    localparam int          W0 = 0;
    localparam logic [31:0] B1 = 32'h0000_0000;
    localparam int          D1 = 32;
    localparam int          W1 = 3;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst  [2];
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [3:0]  sel  [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];
    logic        rty  [2];

    logic [31:0] model [2][32];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_ack [2];
    logic        prev_err [2];

    wishbone_sram_slave #(.BASE_ADDR(B0), .DEPTH_WORDS(D0), .WAIT_CYCLES(W0)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]),
        .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0])
    );

    wishbone_sram_slave #(.BASE_ADDR(B1), .DEPTH_WORDS(D1), .WAIT_CYCLES(W1)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]),
        .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_quiet(input int d, input string tag);
        chk({tag, ".ack"}, 32'(ack[d]), 32'd0);
        chk({tag, ".err"}, 32'(err[d]), 32'd0);
        chk({tag, ".rty"}, 32'(rty[d]), 32'd0);
        chk({tag, ".dat"}, rdat[d], 32'd0);
    endtask

    // One Wishbone access on instance d; hold keeps cyc/stb asserted for a burst.
    task automatic access(input int d, input bit w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] dt, input bit hold,
                          input string tag, output realtime t_ack);
        exp_t        e;
        exp_t        g;
        logic [31:0] base;
        logic [31:0] off;
        int          depth;
        int          waitc;
        int          idx;
        int          n;
        bit          inr;
        bit          seen;
        base  = (d == 0) ? B0 : B1;
        depth = (d == 0) ? D0 : D1;
        waitc = (d == 0) ? W0 : W1;
        off   = a - base;
        inr   = (a >= base) && ((off >> 2) < 32'(depth));
        idx   = int'((off >> 2) & 32'(depth - 1));
        e.is_err = !inr;
        e.lat    = 1 + waitc;
        e.data   = (!w && inr) ? model[d][idx] : 32'h0;
        if (w && inr) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[d][idx][8*b +: 8] = dt[8*b +: 8];
            end
        end
        sb.push_back(e);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = dt;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 24) begin
            @(negedge clk);
            n++;
            seen = ack[d] || err[d];
        end
        g = sb.pop_front();
        chk({tag, ".seen"}, 32'(seen), 32'd1);
        t_ack = $realtime;
        if (seen) begin
            chk({tag, ".ack"}, 32'(ack[d]), 32'(!g.is_err));
            chk({tag, ".err"}, 32'(err[d]), 32'(g.is_err));
            chk({tag, ".dat"}, rdat[d], g.data);
            chk({tag, ".lat"}, 32'(n), 32'(g.lat));
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        end
    endtask

    // Protocol watch: ack/err exclusive and never two cycles in a row.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) begin
                checks++;
                assert (!(ack[d] && err[d]) && !(ack[d] && prev_ack[d]) && !(err[d] && prev_err[d])) else begin
                    errors++;
                    $error("FAIL pulse%0d: observed ack=%b err=%b prev_ack=%b prev_err=%b expected single exclusive pulses",
                           d, ack[d], err[d], prev_ack[d], prev_err[d]);
                end
            end
            prev_ack[d] <= ack[d];
            prev_err[d] <= err[d];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed time limit reached expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        realtime t_now;
        realtime t_prev;
        bit      resp;
        t_prev = 0.0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
            prev_ack[d] = 1'b0; prev_err[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet(0, "rst0_held");
        chk_quiet(1, "rst1_held");
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        chk_quiet(0, "rst0_rel");
        chk_quiet(1, "rst1_rel");

        // Basic write/read, zero wait states
        access(0, 1'b1, B0 + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, "wr10", t_now);
        access(0, 1'b0, B0 + 32'h10, 4'hF, 32'h0, 1'b0, "rd10", t_now);
        access(0, 1'b0, B0 + 32'h13, 4'h0, 32'h0, 1'b0, "rd13_lsb", t_now);

        // Byte lanes and sel = 0
        access(0, 1'b1, B0 + 32'h14, 4'hF, 32'hAABB_CCDD, 1'b0, "wr14", t_now);
        access(0, 1'b1, B0 + 32'h14, 4'h5, 32'h1122_3344, 1'b0, "wr14_sel5", t_now);
        access(0, 1'b0, B0 + 32'h14, 4'hF, 32'h0, 1'b0, "rd14_sel5", t_now);
        access(0, 1'b1, B0 + 32'h14, 4'h0, 32'hFFFF_FFFF, 1'b0, "wr14_sel0", t_now);
        access(0, 1'b0, B0 + 32'h14, 4'h0, 32'h0, 1'b0, "rd14_sel0", t_now);

        // Burst of 8 writes then 8 reads with stb held between acks
        for (int i = 0; i < 8; i++) begin
            access(0, 1'b1, B0 + 32'h20 + 32'(4 * i), 4'hF, 32'hB000_0000 + 32'(i), i < 7, "burst_wr", t_now);
            if (i > 0) chk("burst_wr_gap", 32'(int'(t_now - t_prev)), 32'd20);
            t_prev = t_now;
        end
        for (int i = 0; i < 8; i++) begin
            access(0, 1'b0, B0 + 32'h20 + 32'(4 * i), 4'hF, 32'h0, i < 7, "burst_rd", t_now);
            if (i > 0) chk("burst_rd_gap", 32'(int'(t_now - t_prev)), 32'd20);
            t_prev = t_now;
        end

        // Out of range above and below the window; memory must stay intact
        access(0, 1'b1, B0 + 32'h00, 4'hF, 32'h0102_0304, 1'b0, "wr00", t_now);
        access(0, 1'b1, B0 + 32'(4 * D0), 4'hF, 32'h1234_5678, 1'b0, "err_hi_wr", t_now);
        access(0, 1'b0, B0 + 32'h00, 4'hF, 32'h0, 1'b0, "rd00_after_err", t_now);
        access(0, 1'b0, B0 - 32'h4, 4'hF, 32'h0, 1'b0, "err_lo_rd", t_now);
        access(0, 1'b1, B0 - 32'h4, 4'hF, 32'hFFFF_FFFF, 1'b0, "err_lo_wr", t_now);
        access(0, 1'b0, B0 + 32'h3C, 4'hF, 32'h0, 1'b0, "rd3c_after_err", t_now);

        // Three wait states
        access(1, 1'b1, 32'h40, 4'hF, 32'hCAFE_F00D, 1'b0, "w3_wr40", t_now);
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, "w3_rd40", t_now);

        // Abort: stb dropped in the 2nd wait cycle
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40; sel[1] = 4'hF; wdat[1] = 32'h0BAD_BEEF;
        @(posedge clk);
        @(posedge clk);
        #1;
        stb[1] = 1'b0;
        resp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] || err[1]) resp = 1'b1;
        end
        chk("abort_no_resp", 32'(resp), 32'd0);
        cyc[1] = 1'b0; we[1] = 1'b0;
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, "abort_rd40", t_now);

        // Reset during the wait phase of a write
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40; sel[1] = 4'hF; wdat[1] = 32'h5555_5555;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        chk_quiet(1, "midrst_a");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet(1, "midrst_b");
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        resp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] || err[1]) resp = 1'b1;
        end
        chk("midrst_no_resp", 32'(resp), 32'd0);
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, "midrst_rd40", t_now);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
